// File: rtl/serial_add_sub_if.sv
// Operand/result handshake bundle for serial_add_sub.
// The master side issues operands and consumes results; the slave side is the arithmetic unit.
interface serial_add_sub_if #(
   parameter int WIDTH = 6
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, result, carry_out, overflow
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, result, carry_out, overflow
   );
endinterface

// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor, DIGIT bits per clock, LSB first.
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one digit added per edge, N edges total
// DONE  | result held with out_valid high until out_ready
module serial_add_sub #(
   parameter int WIDTH = 6,
   parameter int DIGIT = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   serial_add_sub_if.slave bus,
   output logic            busy
);
   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("serial_add_sub: WIDTH must be >= 2 and an integer multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] res_shift;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             carry_out_q, carry_out_d;
   logic             overflow_q, overflow_d;
   logic [DIGIT:0]   sum;
   logic             msb_cin;

   assign sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
   // Carry into the top bit of the digit recovered from the sum bit, so DIGIT=1 needs no special case.
   assign msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ sum[DIGIT-1];

   generate
      if (DIGIT == WIDTH) begin : g_res_full
         assign res_shift = sum[DIGIT-1:0];
      end else begin : g_res_shift
         assign res_shift = {sum[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b ^ {WIDTH{bus.sub}};
               carry_d = bus.sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            res_d   = res_shift;
            carry_d = sum[DIGIT];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N - 1)) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               carry_out_d = sum[DIGIT];
               overflow_d  = msb_cin ^ sum[DIGIT];
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = res_q;
   assign bus.carry_out = carry_out_q;
   assign bus.overflow  = overflow_q;
   assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: three instances (6/2, 16/1, 16/16) checked against an arithmetic model.
module tb_serial_add_sub;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_add_sub_if #(.WIDTH(6))  if6 ();
   serial_add_sub_if #(.WIDTH(16)) if16a ();
   serial_add_sub_if #(.WIDTH(16)) if16b ();
   logic busy6, busy16a, busy16b;

   serial_add_sub #(.WIDTH(6),  .DIGIT(2))  u6  (.clk(clk), .rst_n(rst_n), .bus(if6),   .busy(busy6));
   serial_add_sub #(.WIDTH(16), .DIGIT(1))  u16a(.clk(clk), .rst_n(rst_n), .bus(if16a), .busy(busy16a));
   serial_add_sub #(.WIDTH(16), .DIGIT(16)) u16b(.clk(clk), .rst_n(rst_n), .bus(if16b), .busy(busy16b));

   // Reference: plain integer arithmetic on the operand values.
   function automatic void model(input int w, input longint ua, input longint ub, input bit s,
                                 output longint r, output bit c, output bit o);
      longint m, sa, sb, sv;
      m  = longint'(1) << w;
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      if (s) begin
         r  = (((ua - ub) % m) + m) % m;
         c  = (ua >= ub);
         sv = sa - sb;
      end else begin
         r  = (ua + ub) % m;
         c  = (ua + ub) >= m;
         sv = sa + sb;
      end
      o = (sv > m / 2 - 1) || (sv < -(m / 2));
   endfunction

   function automatic int width_of(input int sel);
      return (sel == 0) ? 6 : 16;
   endfunction

   function automatic int n_of(input int sel);
      return (sel == 0) ? 3 : ((sel == 1) ? 16 : 1);
   endfunction

   task automatic set_in(input int sel, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic s);
      case (sel)
         0: begin if6.in_valid = v; if6.a = a[5:0]; if6.b = b[5:0]; if6.sub = s; end
         1: begin if16a.in_valid = v; if16a.a = a; if16a.b = b; if16a.sub = s; end
         default: begin if16b.in_valid = v; if16b.a = a; if16b.b = b; if16b.sub = s; end
      endcase
   endtask

   task automatic set_ordy(input int sel, input logic r);
      case (sel)
         0: if6.out_ready = r;
         1: if16a.out_ready = r;
         default: if16b.out_ready = r;
      endcase
   endtask

   task automatic get(input int sel, output logic ov, output logic ir, output logic bsy,
                      output logic [15:0] r, output logic c, output logic o);
      case (sel)
         0: begin
            ov = if6.out_valid; ir = if6.in_ready; bsy = busy6;
            r = {10'd0, if6.result}; c = if6.carry_out; o = if6.overflow;
         end
         1: begin
            ov = if16a.out_valid; ir = if16a.in_ready; bsy = busy16a;
            r = if16a.result; c = if16a.carry_out; o = if16a.overflow;
         end
         default: begin
            ov = if16b.out_valid; ir = if16b.in_ready; bsy = busy16b;
            r = if16b.result; c = if16b.carry_out; o = if16b.overflow;
         end
      endcase
   endtask

   // Caller is 1 time unit past a rising edge with in_ready high.
   task automatic start_op(input int sel, input logic [15:0] a, input logic [15:0] b, input logic s);
      set_in(sel, 1'b1, a, b, s);
      @(posedge clk);
      #1;
      set_in(sel, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
   endtask

   task automatic wait_done(input int sel, output int lat);
      logic ov, ir, bsy, c, o;
      logic [15:0] r;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         get(sel, ov, ir, bsy, r, c, o);
         if (ov) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic finish_op(input int sel);
      set_ordy(sel, 1'b1);
      @(posedge clk);
      #1;
      set_ordy(sel, 1'b0);
   endtask

   task automatic test_reset();
      logic ov, ir, bsy, c, o;
      logic [15:0] r;
      for (int sel = 0; sel < 3; sel++) begin
         get(sel, ov, ir, bsy, r, c, o);
         n_vec++;
         if ({ov, bsy, r, c, o} !== 20'd0 || ir !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state sel=%0d: got ov=%b ir=%b busy=%b r=%h c=%b o=%b, want all 0 with ir=1",
                     sel, ov, ir, bsy, r, c, o);
         end
      end
   endtask

   logic [5:0] sv_a   [5] = '{6'd63, 6'd31, 6'd32, 6'd5,  6'd63};
   logic [5:0] sv_b   [5] = '{6'd46, 6'd1,  6'd1,  6'd9,  6'd1};
   logic       sv_s   [5] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
   logic [5:0] sv_r   [5] = '{6'b010001, 6'b100000, 6'b011111, 6'b111100, 6'b000000};
   logic       sv_c   [5] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
   logic       sv_o   [5] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0};

   task automatic test_known_vectors();
      logic ov, ir, bsy, c, o;
      logic [15:0] r;
      int lat;
      for (int i = 0; i < 5; i++) begin
         start_op(0, {10'd0, sv_a[i]}, {10'd0, sv_b[i]}, sv_s[i]);
         wait_done(0, lat);
         get(0, ov, ir, bsy, r, c, o);
         n_vec++;
         if (lat !== 3) begin
            n_err++;
            $display("FAIL known_latency #%0d: got %0d want 3", i, lat);
         end
         n_vec++;
         if (r[5:0] !== sv_r[i] || c !== sv_c[i] || o !== sv_o[i]) begin
            n_err++;
            $display("FAIL known_result #%0d: got r=%b c=%b o=%b want r=%b c=%b o=%b",
                     i, r[5:0], c, o, sv_r[i], sv_c[i], sv_o[i]);
         end
         finish_op(0);
         get(0, ov, ir, bsy, r, c, o);
         n_vec++;
         if (ir !== 1'b1 || ov !== 1'b0 || bsy !== 1'b0) begin
            n_err++;
            $display("FAIL known_release #%0d: got ir=%b ov=%b busy=%b want 1 0 0", i, ir, ov, bsy);
         end
      end
   endtask

   task automatic test_random(input int sel, input int count);
      logic ov, ir, bsy, c, o;
      logic [15:0] r, r0, mask, ua, ub;
      logic        us;
      longint      mr;
      bit          mc, mo;
      int          lat, d;
      mask = 16'((32'd1 << width_of(sel)) - 1);
      for (int i = 0; i < count; i++) begin
         ua = 16'($urandom) & mask;
         ub = 16'($urandom) & mask;
         us = 1'($urandom);
         model(width_of(sel), longint'(ua), longint'(ub), us, mr, mc, mo);
         start_op(sel, ua, ub, us);
         wait_done(sel, lat);
         get(sel, ov, ir, bsy, r0, c, o);
         n_vec++;
         if (lat !== n_of(sel)) begin
            n_err++;
            $display("FAIL rand_latency sel=%0d: got %0d want %0d", sel, lat, n_of(sel));
         end
         n_vec++;
         if (r0 !== 16'(mr) || c !== mc || o !== mo) begin
            n_err++;
            $display("FAIL rand_result sel=%0d a=%h b=%h sub=%b: got r=%h c=%b o=%b want r=%h c=%b o=%b",
                     sel, ua, ub, us, r0, c, o, 16'(mr), mc, mo);
         end
         d = $urandom_range(0, 2);
         repeat (d) begin
            @(posedge clk);
            #1;
            get(sel, ov, ir, bsy, r, c, o);
            n_vec++;
            if (ov !== 1'b1 || r !== r0 || ir !== 1'b0) begin
               n_err++;
               $display("FAIL rand_hold sel=%0d: got ov=%b r=%h ir=%b want 1 %h 0", sel, ov, r, r0, ir);
            end
         end
         finish_op(sel);
      end
   endtask

   task automatic test_backpressure();
      logic ov, ir, bsy, c, o;
      logic [15:0] r;
      int lat;
      start_op(0, 16'd63, 16'd46, 1'b1);
      wait_done(0, lat);
      set_in(0, 1'b1, 16'd1, 16'd2, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         get(0, ov, ir, bsy, r, c, o);
         n_vec++;
         if (ov !== 1'b1 || r !== 16'd17 || c !== 1'b1 || o !== 1'b0 || ir !== 1'b0 || bsy !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure_hold k=%0d: got ov=%b r=%0d c=%b o=%b ir=%b busy=%b want 1 17 1 0 0 1",
                     k, ov, r, c, o, ir, bsy);
         end
      end
      // in_valid stays high across the output handshake edge; it must not start a new operation.
      finish_op(0);
      set_in(0, 1'b0, 16'd0, 16'd0, 1'b0);
      get(0, ov, ir, bsy, r, c, o);
      n_vec++;
      if (ir !== 1'b1 || ov !== 1'b0 || bsy !== 1'b0 || r !== 16'd17) begin
         n_err++;
         $display("FAIL backpressure_release: got ir=%b ov=%b busy=%b r=%0d want 1 0 0 17", ir, ov, bsy, r);
      end
   endtask

   task automatic test_reset_mid_run();
      logic ov, ir, bsy, c, o;
      logic [15:0] r;
      int lat;
      start_op(0, 16'd10, 16'd20, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      get(0, ov, ir, bsy, r, c, o);
      n_vec++;
      if (ov !== 1'b0 || r !== 16'd0 || bsy !== 1'b0 || c !== 1'b0 || o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_run: got ov=%b r=%h busy=%b c=%b o=%b want all 0", ov, r, bsy, c, o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      start_op(0, 16'd10, 16'd20, 1'b0);
      wait_done(0, lat);
      get(0, ov, ir, bsy, r, c, o);
      n_vec++;
      if (lat !== 3 || r !== 16'd30 || c !== 1'b0 || o !== 1'b0) begin
         n_err++;
         $display("FAIL after_reset_op: got lat=%0d r=%0d c=%b o=%b want 3 30 0 0", lat, r, c, o);
      end
      finish_op(0);
   endtask

   task automatic test_wide();
      logic ov, ir, bsy, c, o;
      logic [15:0] r;
      int lat;
      for (int sel = 1; sel < 3; sel++) begin
         start_op(sel, 16'h7FFF, 16'h0001, 1'b0);
         wait_done(sel, lat);
         get(sel, ov, ir, bsy, r, c, o);
         n_vec++;
         if (lat !== n_of(sel)) begin
            n_err++;
            $display("FAIL wide_latency sel=%0d: got %0d want %0d", sel, lat, n_of(sel));
         end
         n_vec++;
         if (r !== 16'h8000 || c !== 1'b0 || o !== 1'b1) begin
            n_err++;
            $display("FAIL wide_result sel=%0d: got r=%h c=%b o=%b want 8000 0 1", sel, r, c, o);
         end
         finish_op(sel);
      end
   endtask

   task automatic test_back_to_back();
      logic ov, ir, bsy, c, o;
      logic [15:0] r;
      int lat, t_prev, t_now;
      t_prev = -1;
      for (int i = 0; i < 5; i++) begin
         get(0, ov, ir, bsy, r, c, o);
         n_vec++;
         if (ir !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready #%0d: got in_ready=%b want 1", i, ir);
         end
         start_op(0, 16'(i * 7), 16'(i + 3), 1'b0);
         t_now = cyc;
         if (t_prev >= 0) begin
            n_vec++;
            if (t_now - t_prev !== 5) begin
               n_err++;
               $display("FAIL b2b_period #%0d: got %0d cycles want 5", i, t_now - t_prev);
            end
         end
         t_prev = t_now;
         wait_done(0, lat);
         get(0, ov, ir, bsy, r, c, o);
         n_vec++;
         if (r !== 16'((i * 7 + i + 3) % 64)) begin
            n_err++;
            $display("FAIL b2b_result #%0d: got %0d want %0d", i, r, (i * 7 + i + 3) % 64);
         end
         finish_op(0);
      end
   endtask

   initial begin
      for (int sel = 0; sel < 3; sel++) begin
         set_in(sel, 1'b0, 16'd0, 16'd0, 1'b0);
         set_ordy(sel, 1'b0);
      end
      #22;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_known_vectors();
      test_backpressure();
      test_random(0, 30);
      test_random(1, 6);
      test_random(2, 6);
      test_reset_mid_run();
      test_wide();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
